// File: rtl/fsm_control_imagen_if.sv
`default_nettype none
// ============================================================================
// Module      : fsm_control_imagen_if
// Description : Handshake bundle between the image sequencer and its client.
//               The client drives the request/completion pulses. The
//               sequencer drives the start pulses, row index and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface fsm_control_imagen_if;
    // Requests and completions (client -> sequencer)
    logic       iniciar;
    logic       abortar;
    logic       lectura_completada;
    logic       fila_completa_escrita;
    // Start pulses and status (sequencer -> client)
    logic       iniciar_lectura;
    logic       iniciar_escritura;
    logic [7:0] fila_actual;
    logic       ocupado;
    logic       imagen_completa;
    logic       error_timeout;

    modport master (
        output iniciar,
        output abortar,
        output lectura_completada,
        output fila_completa_escrita,
        input  iniciar_lectura,
        input  iniciar_escritura,
        input  fila_actual,
        input  ocupado,
        input  imagen_completa,
        input  error_timeout
    );

    modport slave (
        input  iniciar,
        input  abortar,
        input  lectura_completada,
        input  fila_completa_escrita,
        output iniciar_lectura,
        output iniciar_escritura,
        output fila_actual,
        output ocupado,
        output imagen_completa,
        output error_timeout
    );
endinterface
`default_nettype wire

// File: rtl/fsm_control_imagen.sv
`default_nettype none
// ============================================================================
// Module      : fsm_control_imagen
// Description : Row-by-row image sequencer. For each of FILAS rows it starts a
//               window read, waits for it, starts a row write, and waits for
//               that. Both waits are guarded by a watchdog, and the FSM parks
//               in an error state if a wait runs too long. Moore machine with
//               registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_control_imagen #(
    parameter int FILAS   = 8,     // rows per image, 1..255
    parameter int TIMEOUT = 1024   // max cycles in a wait state, 2..65535
) (
    input  wire logic              clk,
    input  wire logic              reset,
    fsm_control_imagen_if.slave    ctl
);

    localparam logic [7:0]  ULTIMA_FILA = 8'(FILAS - 1);
    localparam logic [15:0] WD_LIMITE   = 16'(TIMEOUT - 1);

    // 4-bit encoding leaves spare codes, which recover to idle.
    typedef enum logic [3:0] {
        E_REPOSO           = 4'd0,
        E_LEER             = 4'd1,
        E_ESPERA_LECTURA   = 4'd2,
        E_ESCRIBIR         = 4'd3,
        E_ESPERA_ESCRITURA = 4'd4,
        E_SIG_FILA         = 4'd5,
        E_FIN              = 4'd6,
        E_ERROR            = 4'd7
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [7:0]  fila_q,   fila_d;
    logic [15:0] wd_q,     wd_d;
    logic        err_q,    err_d;

    // Registered output pulses and flags, decoded from the next state
    logic        lect_q;
    logic        escr_q;
    logic        ocup_q;
    logic        comp_q;

    logic        wd_vencido;
    logic        en_espera;
    logic        abortable;

    assign wd_vencido = (wd_q == WD_LIMITE);
    assign en_espera  = (estado_q == E_ESPERA_LECTURA) ||
                        (estado_q == E_ESPERA_ESCRITURA);
    // Abort is honoured in every state except idle and error.
    assign abortable  = (estado_q != E_REPOSO) && (estado_q != E_ERROR);

    // Next-state, row index, watchdog and sticky error computation
    always_comb begin
        estado_d = estado_q;
        fila_d   = fila_q;
        err_d    = err_q;

        case (estado_q)
            E_REPOSO: begin
                if (ctl.iniciar) begin
                    estado_d = E_LEER;
                    fila_d   = 8'd0;
                end
            end
            E_LEER: begin
                estado_d = E_ESPERA_LECTURA;
            end
            E_ESPERA_LECTURA: begin
                // A completion in the timeout cycle still wins.
                if (ctl.lectura_completada) begin
                    estado_d = E_ESCRIBIR;
                end else if (wd_vencido) begin
                    estado_d = E_ERROR;
                    err_d    = 1'b1;
                end
            end
            E_ESCRIBIR: begin
                estado_d = E_ESPERA_ESCRITURA;
            end
            E_ESPERA_ESCRITURA: begin
                if (ctl.fila_completa_escrita) begin
                    estado_d = E_SIG_FILA;
                end else if (wd_vencido) begin
                    estado_d = E_ERROR;
                    err_d    = 1'b1;
                end
            end
            E_SIG_FILA: begin
                if (fila_q == ULTIMA_FILA) begin
                    estado_d = E_FIN;
                end else begin
                    estado_d = E_LEER;
                    fila_d   = fila_q + 8'd1;
                end
            end
            E_FIN: begin
                estado_d = E_REPOSO;
            end
            E_ERROR: begin
                if (ctl.iniciar) begin
                    estado_d = E_LEER;
                    fila_d   = 8'd0;
                    err_d    = 1'b0;
                end
            end
            default: begin
                estado_d = E_REPOSO;
                fila_d   = 8'd0;
            end
        endcase

        // Abort outranks every transition computed above.
        if (ctl.abortar && abortable) begin
            estado_d = E_REPOSO;
            fila_d   = 8'd0;
            err_d    = err_q;
        end

        // The watchdog runs only while the FSM stays in the same wait state.
        // Entering a wait state, or any other state, clears it.
        if (en_espera && (estado_d == estado_q)) begin
            wd_d = wd_q + 16'd1;
        end else begin
            wd_d = 16'd0;
        end
    end

    // State, counters and Moore outputs registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= E_REPOSO;
            fila_q   <= 8'd0;
            wd_q     <= 16'd0;
            err_q    <= 1'b0;
            lect_q   <= 1'b0;
            escr_q   <= 1'b0;
            ocup_q   <= 1'b0;
            comp_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            fila_q   <= fila_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            lect_q   <= (estado_d == E_LEER);
            escr_q   <= (estado_d == E_ESCRIBIR);
            ocup_q   <= (estado_d != E_REPOSO) && (estado_d != E_ERROR);
            comp_q   <= (estado_d == E_FIN);
        end
    end

    assign ctl.iniciar_lectura   = lect_q;
    assign ctl.iniciar_escritura = escr_q;
    assign ctl.fila_actual       = fila_q;
    assign ctl.ocupado           = ocup_q;
    assign ctl.imagen_completa   = comp_q;
    assign ctl.error_timeout     = err_q;

endmodule
`default_nettype wire
